stage_execute_mdu: RTL
======================

Name: stage_execute_mdu

Overview:
Parametrised execute stage with an iterative multiply/divide unit (MDU) alongside the single-cycle ALU. It sits between the ID/EX and EX/MEM pipeline registers and keeps forwarding muxes, branch resolution and the EX/MEM register. Multi-cycle MDU ops stall the front end through a busy output to the hazard unit. While an MDU op is busy, bubbles are injected into MEM.

Parameters:
XLEN, 32, datapath width; must be even and >= 8
RA_W, 5, register-address width
MDU_BPC, 1, quotient/product bits resolved per MDU cycle; 1 or 2; must divide XLEN

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_clear  in  1  flush EX/MEM register; aborts the MDU op
mem_stall  in  1  hold EX/MEM register
ex_reg_write, ex_mem_write, ex_mem_read, ex_jump, ex_jump_cond  in  1 each  control from ID/EX
ex_jump_cond_type  in  3  branch condition select
ex_alu_control  in  4  ALU op
ex_alu_src_op1, ex_alu_src_op2, ex_pc_target_src  in  1 each  operand/target selects
ex_result_src  in  2  WB result select
ex_mdu_op  in  3  0 none, 1 MUL, 2 MULH, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2  in  XLEN each  datapath
ex_rd  in  RA_W  destination register
wb_result  in  XLEN  WB forward value
ex_op1_forward, ex_op2_forward  in  2 each  01 WB, 10 MEM, others regfile
mem_reg_write, mem_mem_write, mem_mem_read  out  1 each  registered control
mem_result_src  out  2  registered
mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext  out  XLEN each  registered
mem_rd  out  RA_W  registered
ex_pc_src  out  1  branch/jump taken
ex_pc_target  out  XLEN  target: ALU result when ex_pc_target_src, else ex_pc+ex_imm_ext
ex_mdu_busy  out  1  to hazard unit; stalls IF/ID/EX

Behaviour:
- Reset (reset=0, async): every mem_* output is 0, FSM goes to IDLE, counter and MDU operand/result regs are 0. ex_mdu_busy=0 and ex_pc_src=0 while reset is low.
- Forwarding, op1/op2 selection, target and branch logic are combinational and use the same codes as the port list. ex_pc_src = (jump_cond & cond_true) | jump, gated by reset.
- ex_mdu_op=0: single-cycle path; the EX/MEM register loads on each clk when ~mem_stall, and mem_clear has priority.
- FSM states:
  - IDLE: if ex_mdu_op!=0, ex_mdu_busy=1 combinationally. On clk, latch the forwarded operands and the op, set counter=XLEN/MDU_BPC, and go to CALC.
  - CALC: resolve MDU_BPC bits per cycle (shift-add multiply; restoring divide on magnitudes). Decrement the counter. At counter==1 go to DONE. Busy=1.
  - DONE: busy=0. The MDU result replaces alu_result into mem_alu_result. The EX/MEM register loads the MDU op's control/rd when ~mem_stall, then the FSM returns to IDLE. If mem_stall=1, the FSM holds in DONE.
- Latency: busy for XLEN/MDU_BPC+1 cycles; the result enters MEM at the DONE edge. Default total is 34 cycles.
- While busy, each EX/MEM load (~mem_stall) writes a bubble: reg_write, mem_write and mem_read are 0, and rd is 0.
- Signed ops use magnitudes, then fix the sign. MULH/MULHU return the high XLEN bits of the 2*XLEN product, and MUL returns the low bits.
- Divide by zero: quotient = all ones, remainder = dividend; the FSM still runs to DONE.
- Signed overflow (DIV/REM of most-negative by -1): quotient = most-negative, remainder = 0.
- mem_clear in any state: the EX/MEM register is zeroed, the FSM returns to IDLE on the same edge, and busy is 0 the next cycle.
- mem_clear and a new issue in the same cycle: clear wins and no op is latched.
- MDU ops never assert ex_pc_src; the decoder guarantees jump=jump_cond=0.

Optional Feature:
EX_MDU_EARLY_OUT_EN. When defined, IDLE goes straight to DONE (busy for 1 cycle) in these cases:
- divisor==0;
- unsigned |dividend| < |divisor|: quotient 0, remainder = dividend;
- MUL/MULH/MULHU with an operand of 0: result 0.
Undefined: fixed latency for every MDU op.

Test Plan:
1. ALU ADD rd1=5, imm=7, src_op2=1 -> next edge mem_alu_result=12, mem_reg_write=1; busy never 1.
2. MUL 0x0001_0000 * 0x0001_0000, XLEN=32, BPC=1 -> busy for 33 cycles; mem_alu_result=0, MULHU variant gives 1; a bubble (reg_write=0) precedes the result.
3. DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 7/0 -> 0xFFFF_FFFF; REMU 7/0 -> 7.
4. DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM -> 0.
5. mem_clear asserted on the 10th CALC cycle -> all mem_* 0, busy 0 the next cycle, and a new MUL 3*4 returns 12.
6. mem_stall held 3 cycles in DONE -> FSM stays in DONE and the result loads once on release. Reset pulsed low mid-CALC -> outputs are 0 immediately (async).

Source files
------------

// File: rtl/stage_execute_mdu.sv
// Execute stage: ALU, forwarding, branch resolution, EX/MEM register and an iterative MDU.
// Optional `EX_MDU_EARLY_OUT_EN skips iteration for zero/trivial operands.
module stage_execute_mdu #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int MDU_BPC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_clear,
  input  logic            mem_stall,
  input  logic            ex_reg_write,
  input  logic            ex_mem_write,
  input  logic            ex_mem_read,
  input  logic            ex_jump,
  input  logic            ex_jump_cond,
  input  logic [2:0]      ex_jump_cond_type,
  input  logic [3:0]      ex_alu_control,
  input  logic            ex_alu_src_op1,
  input  logic            ex_alu_src_op2,
  input  logic            ex_pc_target_src,
  input  logic [1:0]      ex_result_src,
  input  logic [2:0]      ex_mdu_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_pc_plus_4,
  input  logic [XLEN-1:0] ex_imm_ext,
  input  logic [XLEN-1:0] ex_rd1,
  input  logic [XLEN-1:0] ex_rd2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [XLEN-1:0] wb_result,
  input  logic [1:0]      ex_op1_forward,
  input  logic [1:0]      ex_op2_forward,
  output logic            mem_reg_write,
  output logic            mem_mem_write,
  output logic            mem_mem_read,
  output logic [1:0]      mem_result_src,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_write_data,
  output logic [XLEN-1:0] mem_pc_plus_4,
  output logic [XLEN-1:0] mem_imm_ext,
  output logic [RA_W-1:0] mem_rd,
  output logic            ex_pc_src,
  output logic [XLEN-1:0] ex_pc_target,
  output logic            ex_mdu_busy
);

  localparam int NSTEP = XLEN / MDU_BPC;
  localparam int CNT_W = $clog2(NSTEP + 1);
  localparam int SH_W  = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_acc, r_q, r_b;
  logic [2:0]        r_op;
  logic              r_neg, r_neg_r, r_dz;

  logic [XLEN-1:0]   w_fwd1, w_fwd2, w_op1, w_op2, w_alu;
  logic              w_cond, w_busy, w_done;
  logic              w_is_div, w_sgn, w_sa, w_sb, w_early;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic [XLEN-1:0]   w_acc, w_q;
  logic [XLEN:0]     w_t, w_diff, w_sum;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_mdu;

  always_comb begin
    case (ex_op1_forward)
      2'b01:   w_fwd1 = wb_result;
      2'b10:   w_fwd1 = mem_alu_result;
      default: w_fwd1 = ex_rd1;
    endcase
    case (ex_op2_forward)
      2'b01:   w_fwd2 = wb_result;
      2'b10:   w_fwd2 = mem_alu_result;
      default: w_fwd2 = ex_rd2;
    endcase
  end

  assign w_op1 = ex_alu_src_op1 ? ex_pc : w_fwd1;
  assign w_op2 = ex_alu_src_op2 ? ex_imm_ext : w_fwd2;

  always_comb begin
    case (ex_alu_control)
      4'd0:    w_alu = w_op1 + w_op2;
      4'd1:    w_alu = w_op1 - w_op2;
      4'd2:    w_alu = w_op1 & w_op2;
      4'd3:    w_alu = w_op1 | w_op2;
      4'd4:    w_alu = w_op1 ^ w_op2;
      4'd5:    w_alu = w_op1 << w_op2[SH_W-1:0];
      4'd6:    w_alu = w_op1 >> w_op2[SH_W-1:0];
      4'd7:    w_alu = XLEN'($signed(w_op1) >>> w_op2[SH_W-1:0]);
      4'd8:    w_alu = XLEN'($signed(w_op1) < $signed(w_op2));
      4'd9:    w_alu = XLEN'(w_op1 < w_op2);
      default: w_alu = w_op2;
    endcase
  end

  always_comb begin
    case (ex_jump_cond_type)
      3'd0:    w_cond = w_fwd1 == w_fwd2;
      3'd1:    w_cond = w_fwd1 != w_fwd2;
      3'd4:    w_cond = $signed(w_fwd1) < $signed(w_fwd2);
      3'd5:    w_cond = $signed(w_fwd1) >= $signed(w_fwd2);
      3'd6:    w_cond = w_fwd1 < w_fwd2;
      3'd7:    w_cond = w_fwd1 >= w_fwd2;
      default: w_cond = 1'b0;
    endcase
  end

  assign ex_pc_src    = reset & ((ex_jump_cond & w_cond) | ex_jump);
  assign ex_pc_target = ex_pc_target_src ? w_alu : ex_pc + ex_imm_ext;

  assign w_is_div = ex_mdu_op[2];
  assign w_sgn    = (ex_mdu_op == 3'd2) | (ex_mdu_op == 3'd4) | (ex_mdu_op == 3'd6);
  assign w_sa     = w_sgn & w_fwd1[XLEN-1];
  assign w_sb     = w_sgn & w_fwd2[XLEN-1];
  assign w_abs_a  = w_sa ? -w_fwd1 : w_fwd1;
  assign w_abs_b  = w_sb ? -w_fwd2 : w_fwd2;

`ifdef EX_MDU_EARLY_OUT_EN
  assign w_early = w_is_div ? ((w_abs_b == '0) | (w_abs_a < w_abs_b))
                            : ((w_fwd1 == '0) | (w_fwd2 == '0));
`else
  assign w_early = 1'b0;
`endif

  // MDU_BPC iterations of shift-add multiply or restoring divide
  always_comb begin
    w_acc  = r_acc;
    w_q    = r_q;
    w_t    = '0;
    w_diff = '0;
    w_sum  = '0;
    for (int i = 0; i < MDU_BPC; i++) begin
      if (r_op[2]) begin
        w_t    = {w_acc, w_q[XLEN-1]};
        w_diff = w_t - {1'b0, r_b};
        w_q    = {w_q[XLEN-2:0], ~w_diff[XLEN]};
        w_acc  = w_diff[XLEN] ? w_t[XLEN-1:0] : w_diff[XLEN-1:0];
      end else begin
        w_sum        = {1'b0, w_acc} + {1'b0, (w_q[0] ? r_b : '0)};
        {w_acc, w_q} = {w_sum, w_q[XLEN-1:1]};
      end
    end
  end

  assign w_prod = r_neg ? -{r_acc, r_q} : {r_acc, r_q};
  assign w_quo  = r_dz ? '1 : (r_neg ? -r_q : r_q);
  assign w_rem  = r_neg_r ? -r_acc : r_acc;

  always_comb begin
    case (r_op)
      3'd1:       w_mdu = w_prod[XLEN-1:0];
      3'd2, 3'd3: w_mdu = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: w_mdu = w_quo;
      default:    w_mdu = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (mem_clear) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (ex_mdu_op != 3'd0) begin
          r_op    <= ex_mdu_op;
          r_b     <= w_is_div ? w_abs_b : w_abs_a;
          r_acc   <= (w_is_div && w_early) ? w_abs_a : '0;
          r_q     <= w_early ? '0 : (w_is_div ? w_abs_a : w_abs_b);
          r_neg   <= w_sa ^ w_sb;
          r_neg_r <= w_sa;
          r_dz    <= w_fwd2 == '0;
          r_cnt   <= CNT_W'(NSTEP);
          r_state <= w_early ? S_DONE : S_CALC;
        end
        S_CALC: begin
          r_acc <= w_acc;
          r_q   <= w_q;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_DONE;
        end
        S_DONE: if (!mem_stall) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy = reset & (((r_state == S_IDLE) & (ex_mdu_op != 3'd0))
                           | (r_state == S_CALC));
  assign w_done = r_state == S_DONE;
  assign ex_mdu_busy = w_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || mem_clear) begin
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_result_src <= '0;
      mem_alu_result <= '0;
      mem_write_data <= '0;
      mem_pc_plus_4  <= '0;
      mem_imm_ext    <= '0;
      mem_rd         <= '0;
    end else if (!mem_stall) begin
      mem_reg_write  <= ex_reg_write & ~w_busy;
      mem_mem_write  <= ex_mem_write & ~w_busy;
      mem_mem_read   <= ex_mem_read & ~w_busy;
      mem_result_src <= ex_result_src;
      mem_alu_result <= w_done ? w_mdu : w_alu;
      mem_write_data <= w_fwd2;
      mem_pc_plus_4  <= ex_pc_plus_4;
      mem_imm_ext    <= ex_imm_ext;
      mem_rd         <= w_busy ? '0 : ex_rd;
    end
  end

endmodule
